// File: rtl/vga_timing_pkg.sv
// Shared raster constants (640x480@60 defaults) and the axis-total helper.
// Latency: n/a (package only). Backpressure: n/a.
package vga_timing_pkg;

    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;
    localparam int DEF_CW       = 12;

    function automatic int axis_total(input int active, input int fp,
                                      input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: position counter with active/sync region decode.
// Latency: count advances on the edge where step is high. Backpressure: none, step-driven.
module vga_axis_counter
    import vga_timing_pkg::*;
#(
    parameter int ACTIVE = DEF_H_ACTIVE,
    parameter int FP     = DEF_H_FP,
    parameter int SYNC   = DEF_H_SYNC,
    parameter int BP     = DEF_H_BP,
    parameter int CW     = DEF_CW
) (
    input  logic          board_clock,
    input  logic          reset,
    input  logic          step,
    output logic [CW-1:0] count,
    output logic          wrap,
    output logic          active,
    output logic          sync
);

    localparam int TOTAL = axis_total(ACTIVE, FP, SYNC, BP);

    if (longint'(TOTAL) > (longint'(1) << CW)) begin : g_bad_total
        $error("vga_axis_counter: axis total does not fit in CW bits");
    end

    // One spare bit so region edges equal to 2^CW still compare correctly.
    localparam logic [CW:0]   ACT_END  = (CW+1)'(ACTIVE);
    localparam logic [CW:0]   SYNC_BEG = (CW+1)'(ACTIVE + FP);
    localparam logic [CW:0]   SYNC_END = (CW+1)'(ACTIVE + FP + SYNC);
    localparam logic [CW-1:0] LAST     = CW'(TOTAL - 1);

    logic [CW:0] count_x;

    assign count_x = {1'b0, count};
    assign wrap    = (count == LAST);
    assign active  = (count_x < ACT_END);
    assign sync    = (count_x >= SYNC_BEG) && (count_x < SYNC_END);

    always_ff @(posedge board_clock) begin
        if (reset) begin
            count <= '0;
        end else if (step) begin
            count <= wrap ? '0 : count + CW'(1);
        end
    end

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised raster timing generator: pixel strobe, h/v counters, syncs, DE, coordinates.
// Latency: outputs show pixel (h,v) one board_clock after the tick that consumed it. Backpressure: none.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0,
    parameter int CLK_DIV  = 1,
    parameter int CW       = DEF_CW
) (
    input  logic          board_clock,
    input  logic          reset,
    output logic          pix_ce,
    output logic          hsync,
    output logic          vsync,
    output logic          de,
    output logic [CW-1:0] x,
    output logic [CW-1:0] y,
    output logic          line_start,
    output logic          frame_start,
    output logic [15:0]   frame_count
);

    if (CLK_DIV < 1) begin : g_bad_div
        $error("vga_timing_gen: CLK_DIV must be >= 1");
    end

    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

    logic [DW-1:0] div;
    logic          tick;
    logic [CW-1:0] h, v;
    logic          h_wrap, h_act, h_sync;
    logic          v_wrap, v_act, v_sync;
    logic          v_step;
    logic          in_active;
    logic          at_origin;

    assign tick      = (div == DIV_LAST);
    assign v_step    = tick && h_wrap;
    assign in_active = h_act && v_act;

    always_ff @(posedge board_clock) begin
        if (reset) begin
            div <= '0;
        end else if (tick) begin
            div <= '0;
        end else begin
            div <= div + DW'(1);
        end
    end

    vga_axis_counter #(
        .ACTIVE (H_ACTIVE),
        .FP     (H_FP),
        .SYNC   (H_SYNC),
        .BP     (H_BP),
        .CW     (CW)
    ) u_h (
        .board_clock (board_clock),
        .reset       (reset),
        .step        (tick),
        .count       (h),
        .wrap        (h_wrap),
        .active      (h_act),
        .sync        (h_sync)
    );

    vga_axis_counter #(
        .ACTIVE (V_ACTIVE),
        .FP     (V_FP),
        .SYNC   (V_SYNC),
        .BP     (V_BP),
        .CW     (CW)
    ) u_v (
        .board_clock (board_clock),
        .reset       (reset),
        .step        (v_step),
        .count       (v),
        .wrap        (v_wrap),
        .active      (v_act),
        .sync        (v_sync)
    );

    // at_origin tracks "(h,v) == (0,0)" so frame_start needs no wide compare.
    always_ff @(posedge board_clock) begin
        if (reset) begin
            at_origin   <= 1'b1;
            pix_ce      <= 1'b0;
            de          <= 1'b0;
            x           <= '0;
            y           <= '0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            frame_count <= '0;
            hsync       <= ~HS_POL;
            vsync       <= ~VS_POL;
        end else if (tick) begin
            at_origin   <= h_wrap && v_wrap;
            pix_ce      <= 1'b1;
            de          <= in_active;
            x           <= in_active ? h : '0;
            y           <= in_active ? v : '0;
            line_start  <= (h == '0);
            frame_start <= at_origin;
            hsync       <= h_sync ? HS_POL : ~HS_POL;
            vsync       <= v_sync ? VS_POL : ~VS_POL;
            if (at_origin) begin
                frame_count <= frame_count + 16'd1;
            end
        end else begin
            pix_ce      <= 1'b0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end
    end

endmodule
